// File: rtl/gpio_pkg.sv
// ---------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the GPIO input-conditioning path:
//   GPIO_MAX_PINS : width of every GPIO bus (64)
//   gpio_bus_t    : full-width GPIO bus type
//   DB_CNT_W      : width of the per-pin debounce counter (8)
//   db_cnt_t      : per-pin debounce counter type
//   presc_width() : prescaler counter width, clog2(n) with a 1-bit minimum
// ---------------------------------------------------------------------------
package gpio_pkg;

  localparam int GPIO_MAX_PINS = 64;
  typedef logic [GPIO_MAX_PINS-1:0] gpio_bus_t;

  localparam int DB_CNT_W = 8;
  typedef logic [DB_CNT_W-1:0] db_cnt_t;

  // A prescaler of 1 still needs a 1-bit counter register.
  function automatic int presc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// ---------------------------------------------------------------------------
// gpio_debounce_bit
// One pin of the input conditioner: two-flop synchroniser, debounce counter,
// stable-level flop and registered edge pulses.
// Ports:
//   cpu_clock   in  system clock, all state on the rising edge
//   reset       in  synchronous active-high reset
//   pad         in  raw asynchronous pad level
//   bypass      in  1 = stable follows the synchronised pad every cycle
//   sample_tick in  shared debounce sample strobe
//   stable      out conditioned level
//   rise        out one-cycle pulse on stable 0->1
//   fall        out one-cycle pulse on stable 1->0
// ---------------------------------------------------------------------------
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int THRESHOLD = 8
) (
  input  logic cpu_clock,
  input  logic reset,
  input  logic pad,
  input  logic bypass,
  input  logic sample_tick,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam db_cnt_t CNT_LAST = db_cnt_t'(THRESHOLD - 1);

  logic    sync1_q, sync2_q;
  logic    stable_q, stable_d;
  db_cnt_t cnt_q, cnt_d;
  logic    rise_q, fall_q;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (bypass) begin
      // Bypass discards any partial count so re-enabling debounce starts clean.
      stable_d = sync2_q;
      cnt_d    = '0;
    end else if (sync2_q == stable_q) begin
      // Any return to the accepted level restarts the count, tick or not.
      cnt_d = '0;
    end else if (sample_tick) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + db_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= pad;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      // Pulses share the edge that updates stable, so they line up with
      // the first cycle the new level is visible.
      rise_q   <= stable_d & ~stable_q;
      fall_q   <= ~stable_d & stable_q;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// ---------------------------------------------------------------------------
// gpio_input_conditioner
// Synchronises raw pad inputs, optionally debounces each pin and produces
// rise/fall event pulses. gpio_in feeds the GPIO device directly.
// Ports:
//   cpu_clock       in  system clock
//   reset           in  synchronous active-high reset
//   pad_in          in  [63:0] raw asynchronous pad levels
//   debounce_bypass in  [63:0] per-pin 1 = skip debounce
//   gpio_in         out [63:0] conditioned level (bits >= PINS are 0)
//   rise_pulse      out [63:0] one-cycle 0->1 event per pin
//   fall_pulse      out [63:0] one-cycle 1->0 event per pin
//   sample_tick     out one-cycle debounce sample strobe
// ---------------------------------------------------------------------------
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int PINS      = 16,
  parameter int PRESCALE  = 1000,
  parameter int THRESHOLD = 8
) (
  input  logic      cpu_clock,
  input  logic      reset,
  input  gpio_bus_t pad_in,
  input  gpio_bus_t debounce_bypass,
  output gpio_bus_t gpio_in,
  output gpio_bus_t rise_pulse,
  output gpio_bus_t fall_pulse,
  output logic      sample_tick
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  // Tick is registered: it is high in the cycle after the counter holds
  // its last value, so with PRESCALE=1 it is high from the second cycle on.
  always_comb begin
    presc_d = presc_q + PW'(1);
    tick_d  = 1'b0;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign sample_tick = tick_q;

  for (genvar gi = 0; gi < GPIO_MAX_PINS; gi++) begin : g_pin
    if (gi < PINS) begin : g_impl
      gpio_debounce_bit #(
        .THRESHOLD (THRESHOLD)
      ) u_bit (
        .cpu_clock   (cpu_clock),
        .reset       (reset),
        .pad         (pad_in[gi]),
        .bypass      (debounce_bypass[gi]),
        .sample_tick (tick_q),
        .stable      (gpio_in[gi]),
        .rise        (rise_pulse[gi]),
        .fall        (fall_pulse[gi])
      );
    end else begin : g_tie
      assign gpio_in[gi]    = 1'b0;
      assign rise_pulse[gi] = 1'b0;
      assign fall_pulse[gi] = 1'b0;
    end
  end

  // Inputs of unimplemented pins are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{pad_in, debounce_bypass};

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_gpio_input_conditioner
// Directed bench for gpio_input_conditioner with PRESCALE=4, THRESHOLD=3,
// PINS=16. t counts rising edges since reset was released; with this
// prescaler sample_tick is high while t%4==0, so debounce samples are taken
// on the edges that produce t = 5, 9, 13, 17, ...
// ---------------------------------------------------------------------------
module tb_gpio_input_conditioner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] pad_in = '0;
  logic [63:0] byp = '0;
  logic [63:0] gpio_in, rise_pulse, fall_pulse;
  logic        sample_tick;

  int t = 0;
  int checks = 0;
  int errors = 0;

  gpio_input_conditioner #(
    .PINS      (16),
    .PRESCALE  (4),
    .THRESHOLD (3)
  ) dut (
    .cpu_clock       (clk),
    .reset           (reset),
    .pad_in          (pad_in),
    .debounce_bypass (byp),
    .gpio_in         (gpio_in),
    .rise_pulse      (rise_pulse),
    .fall_pulse      (fall_pulse),
    .sample_tick     (sample_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) t <= 0;
    else       t <= t + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, t=%0d required finish", t);
    $fatal(1);
  end

  // Advance to the falling edge at which t == k (t only grows while reset is low).
  task automatic goto(input int k);
    while (t < k) @(negedge clk);
  endtask

  // Hold reset for 3 cycles with the given inputs, check all outputs are 0,
  // then release; returns at the negedge where t == 0.
  task automatic do_reset(input logic [63:0] pad, input logic [63:0] b);
    @(negedge clk);
    reset  = 1'b1;
    pad_in = pad;
    byp    = b;
    repeat (3) @(negedge clk);
    checks++;
    if ({gpio_in, rise_pulse, fall_pulse, sample_tick} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gpio=%h rise=%h fall=%h tick=%b, required all 0",
               gpio_in, rise_pulse, fall_pulse, sample_tick);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic exp_tick;
    do_reset(64'hFFFF, 64'h0);
    for (int k = 1; k <= 12; k++) begin
      goto(k);
      exp_tick = (k % 4 == 0);
      checks++;
      if (gpio_in !== 64'h0 || sample_tick !== exp_tick) begin
        errors++;
        $display("FAIL reset_hold t=%0d: gpio=%h tick=%b, required gpio=0 tick=%b",
                 k, gpio_in, sample_tick, exp_tick);
      end
    end
    goto(13);
    checks++;
    if (gpio_in !== 64'hFFFF || rise_pulse !== 64'hFFFF || fall_pulse !== 64'h0) begin
      errors++;
      $display("FAIL reset_accept: gpio=%h rise=%h fall=%h, required FFFF FFFF 0",
               gpio_in, rise_pulse, fall_pulse);
    end
    goto(14);
    checks++;
    if (gpio_in !== 64'hFFFF || rise_pulse !== 64'h0) begin
      errors++;
      $display("FAIL reset_pulse_end: gpio=%h rise=%h, required FFFF 0", gpio_in, rise_pulse);
    end
    $display("test_reset done (t=%0d)", t);
  endtask

  task automatic test_bypass_latency;
    do_reset(64'h0, 64'h1);
    goto(6);
    pad_in[0] = 1'b1;
    goto(8);
    checks++;
    if (gpio_in[0] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_early: gpio[0]=%b, required 0", gpio_in[0]);
    end
    goto(9);
    checks++;
    if (gpio_in[0] !== 1'b1 || rise_pulse[0] !== 1'b1) begin
      errors++;
      $display("FAIL bypass_rise: gpio[0]=%b rise[0]=%b, required 1 1", gpio_in[0], rise_pulse[0]);
    end
    goto(10);
    checks++;
    if (gpio_in[0] !== 1'b1 || rise_pulse[0] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_rise_end: gpio[0]=%b rise[0]=%b, required 1 0", gpio_in[0], rise_pulse[0]);
    end
    pad_in[0] = 1'b0;
    goto(12);
    checks++;
    if (gpio_in[0] !== 1'b1) begin
      errors++;
      $display("FAIL bypass_fall_early: gpio[0]=%b, required 1", gpio_in[0]);
    end
    goto(13);
    checks++;
    if (gpio_in[0] !== 1'b0 || fall_pulse[0] !== 1'b1) begin
      errors++;
      $display("FAIL bypass_fall: gpio[0]=%b fall[0]=%b, required 0 1", gpio_in[0], fall_pulse[0]);
    end
    goto(14);
    checks++;
    if (fall_pulse[0] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_fall_end: fall[0]=%b, required 0", fall_pulse[0]);
    end
    $display("test_bypass_latency done (t=%0d)", t);
  endtask

  task automatic test_debounce_accept;
    do_reset(64'h0, 64'h0);
    goto(5);
    pad_in[3] = 1'b1;            // sync2[3]=1 from t=7; ticks at 9, 13, 17
    for (int k = 6; k <= 16; k++) begin
      goto(k);
      checks++;
      if (gpio_in[3] !== 1'b0 || rise_pulse[3] !== 1'b0) begin
        errors++;
        $display("FAIL accept_early t=%0d: gpio[3]=%b rise[3]=%b, required 0 0",
                 k, gpio_in[3], rise_pulse[3]);
      end
    end
    goto(17);
    checks++;
    if (gpio_in[3] !== 1'b1 || rise_pulse[3] !== 1'b1) begin
      errors++;
      $display("FAIL accept_rise: gpio[3]=%b rise[3]=%b, required 1 1", gpio_in[3], rise_pulse[3]);
    end
    goto(18);
    checks++;
    if (gpio_in[3] !== 1'b1 || rise_pulse[3] !== 1'b0) begin
      errors++;
      $display("FAIL accept_pulse_end: gpio[3]=%b rise[3]=%b, required 1 0", gpio_in[3], rise_pulse[3]);
    end
    $display("test_debounce_accept done (t=%0d)", t);
  endtask

  task automatic test_glitch_reject;
    do_reset(64'h0, 64'h0);
    goto(5);
    pad_in[5] = 1'b1;            // counted at t=9 and t=13
    goto(13);
    pad_in[5] = 1'b0;            // sync2 back to 0 at t=15, before the next sample
    for (int k = 14; k <= 26; k++) begin
      goto(k);
      checks++;
      if (gpio_in[5] !== 1'b0 || rise_pulse[5] !== 1'b0) begin
        errors++;
        $display("FAIL glitch_reject t=%0d: gpio[5]=%b rise[5]=%b, required 0 0",
                 k, gpio_in[5], rise_pulse[5]);
      end
    end
    $display("test_glitch_reject done (t=%0d)", t);
  endtask

  task automatic test_glitch_restart;
    do_reset(64'h0, 64'h0);
    goto(5);
    pad_in[5] = 1'b1;            // count reaches 2 at t=13
    goto(13);
    pad_in[5] = 1'b0;            // one-cycle low: sync2=0 only during t=15
    goto(14);
    pad_in[5] = 1'b1;            // sync2=1 again from t=16; samples at 17, 21, 25
    goto(24);
    checks++;
    if (gpio_in[5] !== 1'b0) begin
      errors++;
      $display("FAIL restart_early: gpio[5]=%b, required 0", gpio_in[5]);
    end
    goto(25);
    checks++;
    if (gpio_in[5] !== 1'b1 || rise_pulse[5] !== 1'b1) begin
      errors++;
      $display("FAIL restart_accept: gpio[5]=%b rise[5]=%b, required 1 1", gpio_in[5], rise_pulse[5]);
    end
    $display("test_glitch_restart done (t=%0d)", t);
  endtask

  task automatic test_fall;
    do_reset(64'h80, 64'h0);     // pin 7 high from release, accepted at t=13
    goto(13);
    checks++;
    if (gpio_in[7] !== 1'b1) begin
      errors++;
      $display("FAIL fall_setup: gpio[7]=%b, required 1", gpio_in[7]);
    end
    pad_in[7] = 1'b0;            // sync2=0 from t=15; samples at 17, 21, 25
    goto(24);
    checks++;
    if (gpio_in[7] !== 1'b1 || fall_pulse[7] !== 1'b0) begin
      errors++;
      $display("FAIL fall_early: gpio[7]=%b fall[7]=%b, required 1 0", gpio_in[7], fall_pulse[7]);
    end
    goto(25);
    checks++;
    if (gpio_in[7] !== 1'b0 || fall_pulse[7] !== 1'b1 || rise_pulse[7] !== 1'b0) begin
      errors++;
      $display("FAIL fall_accept: gpio[7]=%b fall[7]=%b rise[7]=%b, required 0 1 0",
               gpio_in[7], fall_pulse[7], rise_pulse[7]);
    end
    goto(26);
    checks++;
    if (fall_pulse[7] !== 1'b0) begin
      errors++;
      $display("FAIL fall_pulse_end: fall[7]=%b, required 0", fall_pulse[7]);
    end
    $display("test_fall done (t=%0d)", t);
  endtask

  task automatic test_reset_mid_count;
    do_reset(64'h0, 64'h0);
    goto(5);
    pad_in[7] = 1'b1;            // counter at 2 after t=13
    goto(13);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (gpio_in !== 64'h0 || rise_pulse !== 64'h0 || fall_pulse !== 64'h0 || sample_tick !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: gpio=%h rise=%h fall=%h tick=%b, required all 0",
               gpio_in, rise_pulse, fall_pulse, sample_tick);
    end
    reset = 1'b0;
    // A discarded count means the full 3 samples are needed again: t=5,9,13.
    goto(12);
    checks++;
    if (gpio_in[7] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_recount: gpio[7]=%b at t=12, required 0", gpio_in[7]);
    end
    goto(13);
    checks++;
    if (gpio_in[7] !== 1'b1 || rise_pulse[7] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_accept: gpio[7]=%b rise[7]=%b, required 1 1", gpio_in[7], rise_pulse[7]);
    end
    $display("test_reset_mid_count done (t=%0d)", t);
  endtask

  task automatic test_bypass_toggle;
    do_reset(64'h0, 64'h0);
    goto(5);
    pad_in[9] = 1'b1;            // counter at 2 after t=13
    goto(13);
    checks++;
    if (gpio_in[9] !== 1'b0) begin
      errors++;
      $display("FAIL toggle_setup: gpio[9]=%b, required 0", gpio_in[9]);
    end
    byp[9] = 1'b1;
    goto(14);
    checks++;
    if (gpio_in[9] !== 1'b1 || rise_pulse[9] !== 1'b1) begin
      errors++;
      $display("FAIL toggle_load: gpio[9]=%b rise[9]=%b, required 1 1", gpio_in[9], rise_pulse[9]);
    end
    goto(15);
    checks++;
    if (gpio_in[9] !== 1'b1 || rise_pulse[9] !== 1'b0) begin
      errors++;
      $display("FAIL toggle_single_pulse: gpio[9]=%b rise[9]=%b, required 1 0", gpio_in[9], rise_pulse[9]);
    end
    // Back to debounce from a zero count: sync2=0 from t=17, samples 21, 25, 29.
    byp[9]    = 1'b0;
    pad_in[9] = 1'b0;
    goto(28);
    checks++;
    if (gpio_in[9] !== 1'b1) begin
      errors++;
      $display("FAIL toggle_redebounce_early: gpio[9]=%b, required 1", gpio_in[9]);
    end
    goto(29);
    checks++;
    if (gpio_in[9] !== 1'b0 || fall_pulse[9] !== 1'b1) begin
      errors++;
      $display("FAIL toggle_redebounce_fall: gpio[9]=%b fall[9]=%b, required 0 1", gpio_in[9], fall_pulse[9]);
    end
    $display("test_bypass_toggle done (t=%0d)", t);
  endtask

  initial begin
    test_reset();
    test_bypass_latency();
    test_debounce_accept();
    test_glitch_reject();
    test_glitch_restart();
    test_fall();
    test_reset_mid_count();
    test_bypass_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Sits directly upstream of the GPIO device, between the raw input pads and the device's gpio_in bus.
- Synchronises asynchronous pad inputs into cpu_clock, optionally debounces each pin, and produces one-cycle rise/fall event pulses.
- Its output gpio_in feeds the GPIO device unchanged. Its edge pulses are available to a future interrupt block.

Parameters:
- PINS, 16, number of implemented pins (1..64); bits [63:PINS] of every output are tied to 0.
- PRESCALE, 1000, cpu_clock cycles per debounce sample tick (>=1).
- THRESHOLD, 8, consecutive ticks a new level must hold before being accepted (1..255).

Ports:
- cpu_clock  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- pad_in  input  64  raw asynchronous pad levels.
- debounce_bypass  input  64  per-pin: 1 = skip debounce, 0 = debounce.
- gpio_in  output  64  conditioned stable level per pin; connects to the GPIO device's gpio_in.
- rise_pulse  output  64  one-cycle pulse when gpio_in bit goes 0->1.
- fall_pulse  output  64  one-cycle pulse when gpio_in bit goes 1->0.
- sample_tick  output  1  one-cycle prescaler tick (debug/observability).

Behaviour:
- Reset (reset high at a rising edge) clears every register to 0:
  - sync stage 1 and stage 2, stable level (gpio_in), per-pin counters, prescaler, rise_pulse, fall_pulse, sample_tick.
  - Reset has priority over all other activity; asserting it mid-debounce discards the partial count.
- Synchroniser: two flops per pin, sync1 <= pad_in, then sync2 <= sync1. sync2 is the only pad-derived signal used downstream.
- Prescaler:
  - Width is clog2(PRESCALE), with a minimum of 1 bit.
  - Counts 0..PRESCALE-1 and wraps to 0.
  - sample_tick is registered: high in the cycle after the prescaler holds PRESCALE-1.
  - With PRESCALE=1, sample_tick is high every cycle after the first post-reset cycle.
- Bypass pin: stable <= sync2 every cycle; counter held at 0.
  - Latency: pad change present before edge N gives sync1 at N, sync2 at N+1, gpio_in at N+2.
- Debounced pin, evaluated every cycle:
  - sync2 == stable: counter <= 0, regardless of tick, so glitches restart the count.
  - sync2 != stable and sample_tick high, with counter == THRESHOLD-1: stable <= sync2 and counter <= 0.
  - sync2 != stable and sample_tick high otherwise: counter <= counter+1.
  - sync2 != stable and sample_tick low: hold.
  - Counter width is 8 bits; it never exceeds THRESHOLD-1.
- Bypass toggled 1->0 mid-operation: debounce starts from counter 0. Toggled 0->1: the next cycle loads stable from sync2 and discards the count.
- Edge pulses:
  - Registered in the same edge that updates stable.
  - rise_pulse[i] = new stable & ~old stable; fall_pulse[i] = ~new & old.
  - Each pulse is high for exactly the first cycle gpio_in shows the new value.
  - Rise and fall are never high together on one pin.
- Pins i >= PINS: no flops instantiated; gpio_in, rise_pulse and fall_pulse bits are constant 0.

Decomposition:
- Shared package gpio_pkg holds:
  - GPIO_MAX_PINS = 64.
  - Widths of the GPIO buses.
  - The debounce counter width (8).
- Natural sub-module gpio_debounce_bit: one pin's synchroniser, counter, stable flop and edge logic. It takes cpu_clock, reset, pad, bypass and sample_tick, and outputs stable, rise and fall.
- The top level holds the shared prescaler and a generate loop of PINS instances.

Test Plan:
All scenarios use PRESCALE=4, THRESHOLD=3, PINS=16 unless noted.
- Reset check: drive pad_in=64'hFFFF with reset high for 3 cycles, then release -> during reset all outputs are 0. After release with bypass=0, gpio_in[15:0] stays 0 until 3 ticks have elapsed, then becomes 16'hFFFF with rise_pulse=16'hFFFF for exactly 1 cycle. Bits [63:16] remain 0 throughout.
- Bypass latency: bypass[0]=1, pad_in[0] 0->1 before edge N -> gpio_in[0]=1 and rise_pulse[0]=1 from edge N+2, and rise_pulse[0]=0 from edge N+3.
- Debounce accept: bypass=0, pin 3 held at 1 -> gpio_in[3] rises on the edge that processes the 3rd sample_tick after sync2[3]=1, never earlier.
- Glitch rejection: pin 5 pulsed high for 2 ticks then low -> gpio_in[5] stays 0 and no rise_pulse.
- Glitch restart: pin 5 high for 2 ticks, low 1 cycle, then high -> acceptance occurs 3 ticks after the final rise.
- Fall and reset mid-count: pin 7 stable 1 then goes 0 -> fall_pulse[7] is high for 1 cycle at acceptance. Separately, reset asserted with the counter at 2 -> counter, gpio_in and pulses are 0 on the next cycle.
- Bypass toggle mid-count: pin 9 counting at 2, bypass[9] set to 1 -> gpio_in[9] matches sync2[9] next cycle, with a single pulse.
